// File: rtl/latency_histogram_pkg.sv
// Shared constants and helpers for the latency histogram.
// Holds the default geometry, the "invalid sample" latency code and the
// one-hot-to-latency encoding function used by onehot_to_latencia.
package latency_histogram_pkg;

  localparam int DEF_INDEX_WIDTH = 14;
  localparam int DEF_BITS_SHIFT  = 7;
  localparam int DEF_CNT_WIDTH   = 32;

  // Latency code reported for an all-zero or multi-hot sample.
  localparam logic [DEF_BITS_SHIFT-1:0] LAT_INVALID = '1;

  // Widest one-hot index the encoder function can scan.
  localparam int MAX_INDEX_WIDTH = 64;

  // Bit k of a one-hot vector of index_width bits encodes to
  // index_width-1-k, so the MSB is latency 0. Caller guarantees one-hot.
  function automatic int onehot_to_lat(input logic [MAX_INDEX_WIDTH-1:0] onehot,
                                       input int                         index_width);
    int lat;
    lat = 0;
    for (int k = 0; k < MAX_INDEX_WIDTH; k++) begin
      if (k < index_width && onehot[k]) lat = index_width - 1 - k;
    end
    return lat;
  endfunction

endpackage

// File: rtl/latency_histogram_onehot.sv
// onehot_to_latencia: purely combinational encoder from a one-hot bucket
// sample to its latency value, flagging all-zero and multi-hot samples.
module onehot_to_latencia
  import latency_histogram_pkg::*;
#(
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int BITS_SHIFT  = DEF_BITS_SHIFT
) (
  input  logic [INDEX_WIDTH-1:0] i_index,
  output logic [BITS_SHIFT-1:0]  o_latencia,
  output logic                   o_invalid
);

  logic w_is_onehot;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign w_is_onehot = (i_index != '0) &&
                       ((i_index & (i_index - INDEX_WIDTH'(1))) == '0);

  assign o_invalid  = !w_is_onehot;
  assign o_latencia = w_is_onehot
                    ? BITS_SHIFT'(onehot_to_lat(MAX_INDEX_WIDTH'(i_index), INDEX_WIDTH))
                    : '1;

endmodule

// File: rtl/latency_histogram.sv
// latency_histogram: two-stage latency histogram.
//   Stage 1 registers the encoded sample (latencia_valid / latencia).
//   Stage 2 increments the matching bucket, or err_cnt for a rejected sample.
//   Reads are registered and always see the pre-update, pre-clear value.
// Optional build macro LATENCY_HIST_SATURATE_EN: counters saturate at all ones
// instead of wrapping to zero.
module latency_histogram
  import latency_histogram_pkg::*;
#(
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int BITS_SHIFT  = DEF_BITS_SHIFT,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   index_valid,
  input  logic [INDEX_WIDTH-1:0] index,
  input  logic                   clear,
  input  logic                   rd_req,
  input  logic [BITS_SHIFT-1:0]  rd_addr,
  output logic                   latencia_valid,
  output logic [BITS_SHIFT-1:0]  latencia,
  output logic                   rd_valid,
  output logic [CNT_WIDTH-1:0]   rd_data,
  output logic [CNT_WIDTH-1:0]   err_cnt
);

  logic [BITS_SHIFT-1:0] w_enc_lat;
  logic                  w_enc_invalid;
  logic                  w_bucket_inc;
  logic                  w_err_inc;
  logic [CNT_WIDTH-1:0]  w_rd_bucket;

  logic                  r_lat_valid;
  logic [BITS_SHIFT-1:0] r_lat;
  logic                  r_s1_invalid;
  logic                  r_rd_valid;
  logic [CNT_WIDTH-1:0]  r_rd_data;
  logic [CNT_WIDTH-1:0]  r_err_cnt;
  logic [CNT_WIDTH-1:0]  r_bucket [INDEX_WIDTH];

  // Counter step: wraps by default, holds at all ones when saturation is built in.
  function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] v);
`ifdef LATENCY_HIST_SATURATE_EN
    return (v == '1) ? v : v + CNT_WIDTH'(1);
`else
    return v + CNT_WIDTH'(1);
`endif
  endfunction

  onehot_to_latencia #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .BITS_SHIFT  (BITS_SHIFT)
  ) u_encoder (
    .i_index    (index),
    .o_latencia (w_enc_lat),
    .o_invalid  (w_enc_invalid)
  );

  // Clear suppresses the stage-2 update that lands in the same cycle.
  assign w_bucket_inc = r_lat_valid && !r_s1_invalid && !clear;
  assign w_err_inc    = r_lat_valid &&  r_s1_invalid && !clear;

  // Stage 1: capture the encoded sample; clear deliberately leaves it intact.
  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every always_ff reads
    // the pre-edge value of every other register, regardless of block order.
    if (!reset_n) begin
      r_lat_valid  <= 1'b0;
      r_lat        <= '1;
      r_s1_invalid <= 1'b0;
    end else begin
      r_lat_valid <= index_valid;
      if (index_valid) begin
        r_lat        <= w_enc_lat;
        r_s1_invalid <= w_enc_invalid;
      end
    end
  end

  // Stage 2: bump the bucket selected by the stage-1 latency.
  always_ff @(posedge clk) begin
    // NOTE: the bucket array is reset explicitly because its zero state is
    // architecturally visible through reads; this keeps it in flops, not RAM.
    if (!reset_n || clear) begin
      for (int b = 0; b < INDEX_WIDTH; b++) r_bucket[b] <= '0;
    end else if (w_bucket_inc) begin
      for (int b = 0; b < INDEX_WIDTH; b++) begin
        if (r_lat == BITS_SHIFT'(b)) r_bucket[b] <= bump(r_bucket[b]);
      end
    end
  end

  // Stage 2: count rejected samples.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) r_err_cnt <= '0;
    else if (w_err_inc)    r_err_cnt <= bump(r_err_cnt);
  end

  // Read mux: out-of-range addresses match no bucket and return zero.
  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    w_rd_bucket = '0;
    for (int b = 0; b < INDEX_WIDTH; b++) begin
      if (rd_addr == BITS_SHIFT'(b)) w_rd_bucket = r_bucket[b];
    end
  end

  // Registered read port: sees bucket values from before this edge's update/clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_req;
      if (rd_req) r_rd_data <= w_rd_bucket;
    end
  end

  assign latencia_valid = r_lat_valid;
  assign latencia       = r_lat;
  assign rd_valid       = r_rd_valid;
  assign rd_data        = r_rd_data;
  assign err_cnt        = r_err_cnt;

endmodule

// File: tb/tb_latency_histogram.sv
// Self-checking bench for latency_histogram (narrow 4-bit counters so that
// overflow is reachable). A cycle model of the histogram pushes expected
// latencies and read data into scoreboard queues as stimulus is driven;
// they are popped when the DUT strobes its outputs.
module tb_latency_histogram;
  import latency_histogram_pkg::*;

  localparam int IW = 14;
  localparam int BS = 7;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          index_valid;
  logic [IW-1:0] index;
  logic          clear;
  logic          rd_req;
  logic [BS-1:0] rd_addr;
  logic          latencia_valid;
  logic [BS-1:0] latencia;
  logic          rd_valid;
  logic [CW-1:0] rd_data;
  logic [CW-1:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [CW-1:0] m_bucket [IW];
  logic [CW-1:0] m_err;
  logic          m_pend_valid;
  logic          m_pend_inv;
  int            m_pend_lat;

  // Scoreboards.
  logic [BS-1:0] q_lat [$];
  logic [CW-1:0] q_rd  [$];

  latency_histogram #(
    .INDEX_WIDTH (IW),
    .BITS_SHIFT  (BS),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .index_valid    (index_valid),
    .index          (index),
    .clear          (clear),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .latencia_valid (latencia_valid),
    .latencia       (latencia),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .err_cnt        (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected encoding: MSB is latency 0, LSB is latency IW-1, anything not
  // exactly one-hot is the all-ones invalid code.
  function automatic logic [BS-1:0] ref_lat(input logic [IW-1:0] idx);
    if ($countones(idx) != 1) return LAT_INVALID;
    for (int pos = 0; pos < IW; pos++) begin
      if (idx[IW-1-pos]) return BS'(pos);
    end
    return LAT_INVALID;
  endfunction

  function automatic logic [CW-1:0] m_bump(input logic [CW-1:0] v);
`ifdef LATENCY_HIST_SATURATE_EN
    return (v == '1) ? v : v + 1'b1;
`else
    return v + 1'b1;
`endif
  endfunction

  task automatic model_zero();
    for (int b = 0; b < IW; b++) m_bucket[b] = '0;
    m_err = '0;
  endtask

  // Advance the model through the coming edge, then clock the DUT and score.
  task automatic tick();
    logic rst_now;
    rst_now = !reset_n;
    if (rst_now) begin
      model_zero();
      m_pend_valid = 1'b0;
      q_lat.delete();
      q_rd.delete();
    end else begin
      if (rd_req) q_rd.push_back((int'(rd_addr) < IW) ? m_bucket[int'(rd_addr)] : '0);
      if (m_pend_valid && !clear) begin
        if (m_pend_inv) m_err = m_bump(m_err);
        else            m_bucket[m_pend_lat] = m_bump(m_bucket[m_pend_lat]);
      end
      if (clear) model_zero();
      m_pend_valid = index_valid;
      if (index_valid) begin
        m_pend_inv = ($countones(index) != 1);
        m_pend_lat = int'(ref_lat(index));
        q_lat.push_back(ref_lat(index));
      end
    end
    @(posedge clk);
    #1;
    if (rst_now) begin
      check("rst_lat_valid", 32'(latencia_valid), 32'(0));
      check("rst_latencia",  32'(latencia),       32'(LAT_INVALID));
      check("rst_rd_valid",  32'(rd_valid),       32'(0));
      check("rst_rd_data",   32'(rd_data),        32'(0));
      check("rst_err_cnt",   32'(err_cnt),        32'(0));
    end else begin
      check("lat_valid", 32'(latencia_valid), 32'(q_lat.size() != 0));
      if (q_lat.size() != 0) begin
        logic [BS-1:0] exp_lat;
        exp_lat = q_lat.pop_front();
        if (latencia_valid) check("latencia", 32'(latencia), 32'(exp_lat));
      end
      check("rd_valid", 32'(rd_valid), 32'(q_rd.size() != 0));
      if (q_rd.size() != 0) begin
        logic [CW-1:0] exp_rd;
        exp_rd = q_rd.pop_front();
        if (rd_valid) check("rd_data", 32'(rd_data), 32'(exp_rd));
      end
      check("err_cnt", 32'(err_cnt), 32'(m_err));
    end
  endtask

  task automatic idle(input int n);
    index_valid = 1'b0;
    clear       = 1'b0;
    rd_req      = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sample(input logic [IW-1:0] idx);
    index_valid = 1'b1;
    index       = idx;
    tick();
    index_valid = 1'b0;
  endtask

  task automatic read(input int addr);
    rd_req  = 1'b1;
    rd_addr = BS'(addr);
    tick();
    rd_req  = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic read_all();
    for (int b = 0; b < IW; b++) read(b);
  endtask

  initial begin
    reset_n      = 1'b0;
    index_valid  = 1'b0;
    index        = '0;
    clear        = 1'b0;
    rd_req       = 1'b0;
    rd_addr      = '0;
    m_pend_valid = 1'b0;
    m_pend_inv   = 1'b0;
    m_pend_lat   = 0;
    model_zero();

    // Reset state.
    tick();
    tick();

    // First sample accepted on the first edge with reset released:
    // all-zero then multi-hot are both rejected.
    reset_n = 1'b1;
    sample(14'h0000);
    sample(14'h0003);
    idle(1);
    check("invalid_err_cnt", 32'(err_cnt), 32'(2));
    read_all();
    read(14);
    read(100);

    // MSB sample lands in bucket 0.
    sample(14'h2000);
    idle(1);
    read(0);

    // Back-to-back LSB samples all counted in bucket 13.
    sample(14'h0001);
    sample(14'h0001);
    sample(14'h0001);
    idle(1);
    read(13);

    // Read of bucket 5 coinciding with its stage-2 update sees pre-increment 4.
    do_clear();
    for (int i = 0; i < 4; i++) sample(14'h0100);
    idle(1);
    sample(14'h0100);
    read(5);
    read(5);

    // Clear: update in stage 2 dropped, read sees pre-clear value,
    // sample accepted with clear still lands one cycle later.
    sample(14'h0100);
    clear       = 1'b1;
    index_valid = 1'b1;
    index       = 14'h0400;
    rd_req      = 1'b1;
    rd_addr     = BS'(5);
    tick();
    idle(1);
    read_all();

    // Overflow of a 4-bit bucket and of err_cnt.
    do_clear();
    for (int i = 0; i < 16; i++) sample(14'h0800);
    idle(1);
    read(2);
    for (int i = 0; i < 16; i++) sample(14'h0000);
    idle(1);
`ifdef LATENCY_HIST_SATURATE_EN
    check("err_overflow", 32'(err_cnt), 32'(15));
`else
    check("err_overflow", 32'(err_cnt), 32'(0));
`endif

    // Reset mid-stream: in-flight sample and pending read are discarded.
    sample(14'h1000);
    sample(14'h0010);
    index_valid = 1'b1;
    index       = 14'h0020;
    rd_req      = 1'b1;
    rd_addr     = BS'(1);
    reset_n     = 1'b0;
    tick();
    index_valid = 1'b0;
    rd_req      = 1'b0;
    tick();
    reset_n = 1'b1;
    idle(3);
    read_all();
    check("end_lat_queue", 32'(q_lat.size()), 32'(0));
    check("end_rd_queue",  32'(q_rd.size()),  32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/latency_histogram.md
LATENCY_HISTOGRAM -- requirements
Module: latency_histogram

Interface
REQ-001 Parameter INDEX_WIDTH, default 14, one-hot bucket index width and number of histogram buckets.
REQ-002 Parameter BITS_SHIFT, default 7, width of the encoded latency value.
REQ-003 Parameter CNT_WIDTH, default 32, width of each bucket counter and of the error counter.
REQ-004 Ports: one clock; reset is synchronous and active-low.
- clk  input  1  sole clock, all logic on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- index_valid  input  1  qualifies index for one cycle.
- index  input  INDEX_WIDTH  one-hot bucket sample.
- clear  input  1  zeroes all counters.
- rd_req  input  1  single-cycle read request.
- rd_addr  input  BITS_SHIFT  latency value (bucket) to read.
- latencia_valid  output  1  encoded-sample strobe.
- latencia  output  BITS_SHIFT  encoded latency value.
- rd_valid  output  1  read-data strobe.
- rd_data  output  CNT_WIDTH  bucket count.
- err_cnt  output  CNT_WIDTH  count of rejected samples.

Function
REQ-005 Encoding: a one-hot index with bit k set SHALL encode to latencia = INDEX_WIDTH-1-k, so the MSB maps to 0 and the LSB maps to INDEX_WIDTH-1.
REQ-006 All-zero or multi-hot index with index_valid SHALL be invalid: latencia = all ones, no bucket update, err_cnt += 1.
REQ-007 Stage 1: a sample accepted in cycle N SHALL drive latencia_valid/latencia in cycle N+1, one cycle high per sample, including invalid samples.
REQ-008 Stage 2: a valid sample accepted in cycle N SHALL increment bucket[latencia] at the edge ending cycle N+1; back-to-back samples SHALL all be counted with no stall.
REQ-009 Read: rd_req in cycle M SHALL give rd_valid=1 and rd_data in cycle M+1; rd_addr >= INDEX_WIDTH SHALL return 0 with rd_valid=1.
REQ-010 A read and an increment of the same bucket in the same cycle SHALL return the pre-increment value.
REQ-011 clear in cycle C SHALL zero all bucket counters and err_cnt at the end of C; a stage-2 increment or err_cnt increment in the same cycle SHALL be dropped; a read in C SHALL return the pre-clear value.
REQ-012 clear SHALL NOT flush the stage-1 register; a sample in flight at clear completes its update one cycle later.
REQ-013 Counter overflow SHALL follow REQ-018.

Reset
REQ-014 With reset_n=0 at a clock edge: latencia_valid=0, latencia=all ones, rd_valid=0, rd_data=0, err_cnt=0, all bucket counters=0, and the pipeline register empty.
REQ-015 Reset mid-operation SHALL discard in-flight samples and pending reads with no residual update after release.
REQ-016 The first sample SHALL be accepted at the first edge with reset_n=1.

Configuration
REQ-017 Macro LATENCY_HIST_SATURATE_EN SHALL control counter overflow.
REQ-018 With the macro defined, bucket counters and err_cnt SHALL saturate at 2^CNT_WIDTH-1. Without it, they SHALL wrap to 0.

Structure
REQ-019 The shared package SHALL hold the default INDEX_WIDTH/BITS_SHIFT/CNT_WIDTH constants, the invalid-latency constant (all ones) and a function computing the encoded value.
REQ-020 One sub-module onehot_to_latencia (combinational, parameterised INDEX_WIDTH/BITS_SHIFT, outputs latencia and an invalid flag) SHALL perform the encoding; the pipeline and counters stay in latency_histogram.

Verification
REQ-021 Defaults: index=14'h2000 with valid in cycle N -> latencia_valid=1, latencia=0 at N+1; bucket[0] reads 1.
REQ-022 Send index 14'h0001 three consecutive cycles -> three latencia=13 strobes; rd_addr=13 returns 3.
REQ-023 Send index 14'h0000, then 14'h0003 -> latencia=7'h7F twice; err_cnt=2; all buckets read 0.
REQ-024 rd_req rd_addr=5 in the same cycle as the stage-2 update of bucket 5 (count 4) -> rd_data=4; the next read returns 5.
REQ-025 Assert clear while a sample is in stage 1 -> all counters read 0 except the in-flight bucket, which reads 1.
REQ-026 CNT_WIDTH=4, bucket preloaded to 15 by sixteen samples -> reads 15 with LATENCY_HIST_SATURATE_EN defined, 0 without; reset_n=0 mid-stream -> all outputs and counters 0.
